// File: rtl/cpu_p_pkg.sv
// Shared constants, state encodings and the hex-to-segment lookup for the GCD node.
package cpu_p_pkg;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 9600;
  localparam int SCAN_CYC = 100_000;

  // Rounded to the nearest whole cycle so 100 MHz / 9600 gives 10417.
  function automatic int bit_cycles(input int clkFreq, input int baud);
    return (clkFreq + baud / 2) / baud;
  endfunction

  localparam int BIT_CYC = bit_cycles(CLK_FREQ, BAUD);

  typedef enum logic [2:0] {
    ST_WAIT_A,
    ST_WAIT_B,
    ST_CALC,
    ST_SEND,
    ST_WAIT_TX
  } ctrl_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Active-low segments, bit order gfedcba.
  function automatic logic [6:0] seg7(input logic [3:0] hex);
    logic [6:0] seg;
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/cpu_p_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, framing check.
module cpu_p_uart_rx #(
  parameter int BIT_CYC = cpu_p_pkg::BIT_CYC
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o
);
  import cpu_p_pkg::*;

  localparam int CW = $clog2(BIT_CYC);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYC / 2 - 1);

  rx_state_e     state_q, state_d;
  logic          sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;

  // Synchronizer and edge history reset to the idle-high line level so release never looks like a start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      sync1_q  <= rx_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      valid_q  <= valid_d;
    end
  end

  // Frame sequencing: half a bit to the start-bit re-check, then a full bit between samples.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    valid_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: if (cnt_q == HALF) begin
        cnt_d    = '0;
        bitIdx_d = '0;
        state_d  = sync2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == LAST) begin
        cnt_d   = '0;
        shift_d = {sync2_q, shift_q[7:1]};
        if (bitIdx_q == 3'd7) state_d = RX_STOP;
        else bitIdx_d = bitIdx_q + 3'd1;
      end
      RX_STOP: if (cnt_q == LAST) begin
        cnt_d   = '0;
        valid_d = sync2_q;
        state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_valid_o = valid_q;
  assign rx_data_o  = shift_q;

endmodule

// File: rtl/cpu_p.sv
// cpu_p: receives two bytes over UART, computes their GCD, displays and echoes the result.
module cpu_p #(
  parameter int CLK_FREQ = cpu_p_pkg::CLK_FREQ,
  parameter int BAUD     = cpu_p_pkg::BAUD,
  parameter int SCAN_CYC = cpu_p_pkg::SCAN_CYC
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [7:0]  switch,
  input  logic        UART_RX,
  output logic [11:0] digi,
  output logic [7:0]  led,
  output logic        UART_TX
);
  import cpu_p_pkg::*;

  localparam int TX_BIT_CYC = bit_cycles(CLK_FREQ, BAUD);
  localparam int TCW = $clog2(TX_BIT_CYC);
  localparam logic [TCW-1:0] TX_LAST = TCW'(TX_BIT_CYC - 1);
  localparam int SCW = $clog2(SCAN_CYC);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_CYC - 1);

  logic        rxValid;
  logic [7:0]  rxData;
  ctrl_state_e state_q, state_d;
  logic [7:0]  opA_q, opA_d, opB_q, opB_d, x_q, x_d, y_q, y_d, result_q, result_d;
  logic        txStart, txDone, txBusy_q;
  logic [9:0]  txShift_q;
  logic [3:0]  txBitCnt_q;
  logic [TCW-1:0] txCnt_q;
  logic [SCW-1:0] scanCnt_q;
  logic [1:0]  digitSel_q;
  logic [15:0] dispWord;
  logic [3:0]  nibble;
  logic [11:0] digi_q;
  logic        unusedSwitch;

  assign unusedSwitch = ^switch[7:1];

  cpu_p_uart_rx #(.BIT_CYC(TX_BIT_CYC)) uRx (
    .clk_i      (sysclk),
    .rst_ni     (reset),
    .rx_i       (UART_RX),
    .rx_valid_o (rxValid),
    .rx_data_o  (rxData)
  );

  // Control state and operand/result registers.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_WAIT_A;
      opA_q    <= '0;
      opB_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
    end
  end

  // Operand capture, subtractive GCD one step per cycle, then hand the result to the transmitter.
  always_comb begin
    state_d  = state_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
    txStart  = 1'b0;
    case (state_q)
      ST_WAIT_A: if (rxValid) begin
        opA_d   = rxData;
        state_d = ST_WAIT_B;
      end
      ST_WAIT_B: if (rxValid) begin
        opB_d   = rxData;
        x_d     = opA_q;
        y_d     = rxData;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        if (x_q == 8'd0 || x_q == y_q) begin
          result_d = y_q;
          state_d  = ST_SEND;
        end else if (y_q == 8'd0) begin
          result_d = x_q;
          state_d  = ST_SEND;
        end else if (x_q > y_q) begin
          x_d = x_q - y_q;
        end else begin
          y_d = y_q - x_q;
        end
      end
      ST_SEND: begin
        txStart = 1'b1;
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: if (txDone) state_d = ST_WAIT_A;
      default: state_d = ST_WAIT_A;
    endcase
  end

  // Transmitter: the shift register idles at all ones so its LSB drives the line directly.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      txBusy_q   <= 1'b0;
      txShift_q  <= '1;
      txBitCnt_q <= '0;
      txCnt_q    <= '0;
    end else if (!txBusy_q) begin
      if (txStart) begin
        txBusy_q   <= 1'b1;
        txShift_q  <= {1'b1, result_q, 1'b0};
        txBitCnt_q <= '0;
        txCnt_q    <= '0;
      end
    end else if (txCnt_q == TX_LAST) begin
      txCnt_q <= '0;
      if (txBitCnt_q == 4'd9) begin
        txBusy_q <= 1'b0;
      end else begin
        txBitCnt_q <= txBitCnt_q + 4'd1;
        txShift_q  <= {1'b1, txShift_q[9:1]};
      end
    end else begin
      txCnt_q <= txCnt_q + 1'b1;
    end
  end

  assign txDone  = txBusy_q && (txCnt_q == TX_LAST) && (txBitCnt_q == 4'd9);
  assign UART_TX = txShift_q[0];
  assign led     = result_q;

  // Digit scan timer: one digit per SCAN_CYC cycles, rightmost first.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      scanCnt_q  <= '0;
      digitSel_q <= '0;
    end else if (scanCnt_q == SCAN_LAST) begin
      scanCnt_q  <= '0;
      digitSel_q <= digitSel_q + 2'd1;
    end else begin
      scanCnt_q <= scanCnt_q + 1'b1;
    end
  end

  // Pick the nibble for the active digit: A on the left pair, B or the result on the right pair.
  always_comb begin
    dispWord = {opA_q, switch[0] ? result_q : opB_q};
    nibble   = dispWord[{digitSel_q, 2'b00} +: 4];
  end

  // Registered display drive, all segments and digits dark while in reset.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) digi_q <= 12'hFFF;
    else        digi_q <= {~(4'b0001 << digitSel_q), 1'b1, seg7(nibble)};
  end

  assign digi = digi_q;

endmodule

// File: tb/tb_cpu_p.sv
// Self-checking bench for cpu_p with a shortened bit period and scan time.
module tb_cpu_p;

  localparam int CLK_FREQ = 1600;
  localparam int BAUD     = 100;
  localparam int BIT_CYC  = 16;
  localparam int SCAN_CYC = 40;
  localparam int TX_BOUND = 256 + 12 * BIT_CYC + 64;

  logic        sysclk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  switch = 8'h00;
  logic        UART_RX = 1'b1;
  logic [11:0] digi;
  logic [7:0]  led;
  logic        UART_TX;

  int assertCount = 0;
  int failCount = 0;
  logic [8:0] txQ[$];
  logic [6:0] segTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  cpu_p #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .SCAN_CYC(SCAN_CYC)) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .switch  (switch),
    .UART_RX (UART_RX),
    .digi    (digi),
    .led     (led),
    .UART_TX (UART_TX)
  );

  always #5 sysclk = ~sysclk;

  // Decodes every frame on UART_TX into {stop bit, data byte}.
  initial begin : txMonitor
    logic [7:0] b;
    logic stopBit;
    forever begin
      @(negedge UART_TX);
      repeat (BIT_CYC / 2) @(posedge sysclk);
      #1;
      if (UART_TX == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CYC) @(posedge sysclk);
          #1;
          b[i] = UART_TX;
        end
        repeat (BIT_CYC) @(posedge sysclk);
        #1;
        stopBit = UART_TX;
        txQ.push_back({stopBit, b});
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] gcdModel(input logic [7:0] a, input logic [7:0] b);
    int p, q, t;
    p = a;
    q = b;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p[7:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] d, input logic stopBit);
    UART_RX = 1'b0;
    tick(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      UART_RX = d[i];
      tick(BIT_CYC);
    end
    UART_RX = stopBit;
    tick(BIT_CYC);
    UART_RX = 1'b1;
  endtask

  task automatic sendPair(input logic [7:0] a, input logic [7:0] b);
    sendByte(a, 1'b1);
    tick(2 * BIT_CYC);
    sendByte(b, 1'b1);
  endtask

  task automatic waitTx(output logic [8:0] frm, output bit timedOut);
    frm = 'x;
    timedOut = 1'b1;
    for (int i = 0; i < TX_BOUND; i++) begin
      if (txQ.size() > 0) begin
        frm = txQ.pop_front();
        timedOut = 1'b0;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset;
    logic [3:0] expEn;
    int runLen;
    tick(3);
    assertCount++;
    if (digi !== 12'hFFF) begin failCount++; $display("[TB] FAIL reset_digi: got %h expected fff", digi); end
    assertCount++;
    if (led !== 8'h00) begin failCount++; $display("[TB] FAIL reset_led: got %h expected 00", led); end
    assertCount++;
    if (UART_TX !== 1'b1) begin failCount++; $display("[TB] FAIL reset_tx: got %b expected 1", UART_TX); end
    reset = 1'b1;
    tick(1);
    assertCount++;
    if (digi[7:0] !== {1'b1, segTable[0]}) begin
      failCount++; $display("[TB] FAIL reset_first_digit: got %h expected %h", digi[7:0], {1'b1, segTable[0]});
    end
    for (int k = 0; k < 5; k++) begin
      expEn = ~(4'b0001 << (k % 4));
      assertCount++;
      if (digi[11:8] !== expEn) begin
        failCount++; $display("[TB] FAIL scan_order%0d: got %b expected %b", k, digi[11:8], expEn);
      end
      runLen = 0;
      while (digi[11:8] === expEn && runLen < 2 * SCAN_CYC) begin
        runLen++;
        tick(1);
      end
      assertCount++;
      if (runLen != SCAN_CYC) begin
        failCount++; $display("[TB] FAIL scan_period%0d: got %0d expected %0d", k, runLen, SCAN_CYC);
      end
    end
  endtask

  task automatic test_basic;
    logic [8:0] frm;
    bit timedOut;
    int waited;
    sendPair(8'h55, 8'hFF);
    waited = 0;
    while (led !== 8'h55 && waited < 256) begin
      waited++;
      tick(1);
    end
    assertCount++;
    if (led !== 8'h55) begin failCount++; $display("[TB] FAIL basic_led_latency: got %h expected 55", led); end
    waitTx(frm, timedOut);
    assertCount++;
    if (timedOut || frm !== {1'b1, 8'h55}) begin
      failCount++; $display("[TB] FAIL basic_tx: got %h (timeout %0d) expected %h", frm, timedOut, {1'b1, 8'h55});
    end
  endtask

  task automatic test_display;
    logic [8:0] frm;
    bit timedOut, found;
    logic [15:0] dispWord;
    logic [3:0] expEn;
    logic [7:0] g;
    g = gcdModel(8'hFA, 8'hC6);
    sendPair(8'hFA, 8'hC6);
    waitTx(frm, timedOut);
    assertCount++;
    if (timedOut || frm !== {1'b1, g}) begin
      failCount++; $display("[TB] FAIL disp_tx: got %h (timeout %0d) expected %h", frm, timedOut, {1'b1, g});
    end
    assertCount++;
    if (led !== g) begin failCount++; $display("[TB] FAIL disp_led: got %h expected %h", led, g); end
    for (int sw = 1; sw >= 0; sw--) begin
      switch = {7'd0, sw[0]};
      tick(2);
      dispWord = {8'hFA, (sw != 0) ? g : 8'hC6};
      for (int d = 0; d < 4; d++) begin
        expEn = ~(4'b0001 << d);
        found = 1'b0;
        for (int c = 0; c < 5 * SCAN_CYC; c++) begin
          if (digi[11:8] === expEn) begin
            found = 1'b1;
            break;
          end
          tick(1);
        end
        assertCount++;
        if (!found || digi[7:0] !== {1'b1, segTable[dispWord[4*d +: 4]]}) begin
          failCount++;
          $display("[TB] FAIL disp_sw%0d_digit%0d: got %h (found %0d) expected %h", sw, d, digi[7:0], found,
                   {1'b1, segTable[dispWord[4*d +: 4]]});
        end
      end
    end
  endtask

  task automatic test_zero;
    logic [8:0] frm;
    bit timedOut;
    logic [7:0] aList [3] = '{8'h00, 8'h00, 8'h07};
    logic [7:0] bList [3] = '{8'h00, 8'h07, 8'h00};
    logic [7:0] g;
    for (int i = 0; i < 3; i++) begin
      g = gcdModel(aList[i], bList[i]);
      sendPair(aList[i], bList[i]);
      waitTx(frm, timedOut);
      assertCount++;
      if (timedOut || frm !== {1'b1, g}) begin
        failCount++; $display("[TB] FAIL zero%0d_tx: got %h (timeout %0d) expected %h", i, frm, timedOut, {1'b1, g});
      end
      assertCount++;
      if (led !== g) begin failCount++; $display("[TB] FAIL zero%0d_led: got %h expected %h", i, led, g); end
    end
  endtask

  task automatic test_random;
    logic [8:0] frm;
    bit timedOut;
    logic [7:0] a, b, g;
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      g = gcdModel(a, b);
      sendPair(a, b);
      waitTx(frm, timedOut);
      assertCount++;
      if (timedOut || frm !== {1'b1, g}) begin
        failCount++; $display("[TB] FAIL rand%0d_tx(%h,%h): got %h (timeout %0d) expected %h", i, a, b, frm, timedOut, {1'b1, g});
      end
      assertCount++;
      if (led !== g) begin failCount++; $display("[TB] FAIL rand%0d_led(%h,%h): got %h expected %h", i, a, b, led, g); end
    end
  endtask

  task automatic test_framing;
    logic [8:0] frm;
    bit timedOut;
    sendByte(8'h30, 1'b0);
    tick(2 * BIT_CYC);
    sendPair(8'h12, 8'h08);
    waitTx(frm, timedOut);
    assertCount++;
    if (timedOut || frm !== {1'b1, gcdModel(8'h12, 8'h08)}) begin
      failCount++; $display("[TB] FAIL framing_err_tx: got %h (timeout %0d) expected %h", frm, timedOut, {1'b1, gcdModel(8'h12, 8'h08)});
    end
    tick(BIT_CYC);
    UART_RX = 1'b0;
    tick(3);
    UART_RX = 1'b1;
    tick(2 * BIT_CYC);
    sendPair(8'h0C, 8'h12);
    waitTx(frm, timedOut);
    assertCount++;
    if (timedOut || frm !== {1'b1, gcdModel(8'h0C, 8'h12)}) begin
      failCount++; $display("[TB] FAIL glitch_tx: got %h (timeout %0d) expected %h", frm, timedOut, {1'b1, gcdModel(8'h0C, 8'h12)});
    end
  endtask

  task automatic test_reset_mid;
    logic [8:0] frm;
    bit timedOut, sawStart;
    // Reset while the long 255/1 calculation is running.
    sendPair(8'hFF, 8'h01);
    tick(20);
    reset = 1'b0;
    #1;
    assertCount++;
    if (UART_TX !== 1'b1 || led !== 8'h00 || digi !== 12'hFFF) begin
      failCount++; $display("[TB] FAIL reset_mid_calc: got tx=%b led=%h digi=%h expected tx=1 led=00 digi=fff", UART_TX, led, digi);
    end
    tick(3);
    reset = 1'b1;
    tick(2);
    sendPair(8'h24, 8'h10);
    waitTx(frm, timedOut);
    assertCount++;
    if (timedOut || frm !== {1'b1, gcdModel(8'h24, 8'h10)}) begin
      failCount++; $display("[TB] FAIL after_calc_reset_tx: got %h (timeout %0d) expected %h", frm, timedOut, {1'b1, gcdModel(8'h24, 8'h10)});
    end
    // Reset in the middle of a transmitted frame.
    sendPair(8'h21, 8'h0B);
    sawStart = 1'b0;
    for (int i = 0; i < TX_BOUND; i++) begin
      if (UART_TX === 1'b0) begin
        sawStart = 1'b1;
        break;
      end
      tick(1);
    end
    assertCount++;
    if (!sawStart) begin failCount++; $display("[TB] FAIL mid_tx_start: got no start bit expected start bit"); end
    tick(3 * BIT_CYC);
    reset = 1'b0;
    #1;
    assertCount++;
    if (UART_TX !== 1'b1 || led !== 8'h00) begin
      failCount++; $display("[TB] FAIL reset_mid_tx: got tx=%b led=%h expected tx=1 led=00", UART_TX, led);
    end
    tick(3);
    reset = 1'b1;
    tick(12 * BIT_CYC);
    txQ.delete();
    sendPair(8'h1C, 8'h0E);
    waitTx(frm, timedOut);
    assertCount++;
    if (timedOut || frm !== {1'b1, gcdModel(8'h1C, 8'h0E)}) begin
      failCount++; $display("[TB] FAIL after_tx_reset_tx: got %h (timeout %0d) expected %h", frm, timedOut, {1'b1, gcdModel(8'h1C, 8'h0E)});
    end
  endtask

  initial begin : mainSeq
    test_reset();
    test_basic();
    test_display();
    test_zero();
    test_random();
    test_framing();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
